// File: rtl/x9_sequencer.sv
// Program sequencer: IDLE/RUN/DONE control, branch LUT, lagging ALU flag
// registers and a saturating executed-cycle counter.
module x9_sequencer #(
    parameter int D         = 12,
    parameter int LW        = 4,
    parameter int CW        = 16,
    parameter int DONE_ADDR = 165
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          branch,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    input  logic          one_i,
    input  logic          pari_i,
    input  logic          sc_o,
    input  logic          sc_clr,
    input  logic          sc_en,
    output logic [D-1:0]  prog_ctr,
    output logic          one_q,
    output logic          pari_q,
    output logic          sc_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int          ENTRIES = 1 << LW;
    localparam logic [31:0] DONE_W  = DONE_ADDR;
    localparam logic [D-1:0]  PC_ONE  = 1;
    localparam logic [CW-1:0] CYC_ONE = 1;

    state_t         state;
    logic [D-1:0]   lut [ENTRIES];
    logic [D-1:0]   next_pc;
    logic [CW-1:0]  next_cycles;
    logic           at_done;

    // Compare at 32 bits so a DONE_ADDR beyond the PC range is never matched.
    assign at_done     = (32'(prog_ctr) == DONE_W);
    assign next_pc     = (branch && one_q) ? lut[lut_idx] : prog_ctr + PC_ONE;
    assign next_cycles = (cycles == '1) ? cycles : cycles + CYC_ONE;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    // Abort (req low) outranks reaching DONE_ADDR; stall freezes PC, flags and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            prog_ctr <= '0;
            one_q    <= 1'b0;
            pari_q   <= 1'b0;
            sc_in    <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    prog_ctr <= '0;
                    if (req) begin
                        state  <= ST_RUN;
                        cycles <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        one_q  <= one_i;
                        pari_q <= pari_i;
                        cycles <= next_cycles;
                        if (sc_clr) begin
                            sc_in <= 1'b0;
                        end else if (sc_en) begin
                            sc_in <= sc_o;
                        end
                    end
                    if (!req) begin
                        state    <= ST_IDLE;
                        prog_ctr <= '0;
                    end else if (at_done) begin
                        state <= ST_DONE;
                    end else if (!stall) begin
                        prog_ctr <= next_pc;
                    end
                end
                ST_DONE: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        prog_ctr <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    prog_ctr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x9_sequencer.sv
// Bench for x9_sequencer: vector table through a scoreboard queue, plus
// hand-written run, stall, abort, reset, wrap and saturation sequences.
module tb_x9_sequencer;

    typedef struct {
        logic       req, stall, branch;
        logic [3:0] idx;
        logic       one, pari, sco, clr, en;
        int         pc;
        logic       busy, done, oneq, pariq, scin;
        int         cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, stall = 1'b0, branch = 1'b0;
    logic [3:0]  lut_idx = '0, lut_waddr = '0;
    logic        lut_we = 1'b0;
    logic [11:0] lut_wdata = '0;
    logic        one_i = 1'b0, pari_i = 1'b0, sc_o = 1'b0, sc_clr = 1'b0, sc_en = 1'b0;
    logic [11:0] prog_ctr;
    logic        one_q, pari_q, sc_in, busy, done;
    logic [15:0] cycles;

    logic        b_req = 1'b0, c_req = 1'b0;
    logic        zero1 = 1'b0;
    logic [1:0]  zero2 = '0;
    logic [3:0]  zero4 = '0;
    logic [3:0]  b_pc, c_pc;
    logic        b_one, b_pari, b_sc, b_busy, b_done;
    logic        c_one, c_pari, c_sc, c_busy, c_done;
    logic [15:0] b_cycles;
    logic [3:0]  c_cycles;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    x9_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall), .branch(branch),
        .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .one_i(one_i), .pari_i(pari_i), .sc_o(sc_o), .sc_clr(sc_clr), .sc_en(sc_en),
        .prog_ctr(prog_ctr), .one_q(one_q), .pari_q(pari_q), .sc_in(sc_in),
        .busy(busy), .done(done), .cycles(cycles)
    );

    x9_sequencer #(.D(4), .LW(2), .CW(16), .DONE_ADDR(15)) dut_b (
        .clk(clk), .reset(reset), .req(b_req), .stall(zero1), .branch(zero1),
        .lut_idx(zero2), .lut_we(zero1), .lut_waddr(zero2), .lut_wdata(zero4),
        .one_i(zero1), .pari_i(zero1), .sc_o(zero1), .sc_clr(zero1), .sc_en(zero1),
        .prog_ctr(b_pc), .one_q(b_one), .pari_q(b_pari), .sc_in(b_sc),
        .busy(b_busy), .done(b_done), .cycles(b_cycles)
    );

    x9_sequencer #(.D(4), .LW(2), .CW(4), .DONE_ADDR(20)) dut_c (
        .clk(clk), .reset(reset), .req(c_req), .stall(zero1), .branch(zero1),
        .lut_idx(zero2), .lut_we(zero1), .lut_waddr(zero2), .lut_wdata(zero4),
        .one_i(zero1), .pari_i(zero1), .sc_o(zero1), .sc_clr(zero1), .sc_en(zero1),
        .prog_ctr(c_pc), .one_q(c_one), .pari_q(c_pari), .sc_in(c_sc),
        .busy(c_busy), .done(c_done), .cycles(c_cycles)
    );

    function automatic vec_t mk(input int r, s, b, idx, o, p, sco, clr, en,
                                input int pc, bsy, dn, oq, pq, si, cyc);
        vec_t v;
        v.req = 1'(r);  v.stall = 1'(s);  v.branch = 1'(b);  v.idx = 4'(idx);
        v.one = 1'(o);  v.pari = 1'(p);   v.sco = 1'(sco);   v.clr = 1'(clr);
        v.en = 1'(en);  v.pc = pc;        v.busy = 1'(bsy);  v.done = 1'(dn);
        v.oneq = 1'(oq); v.pariq = 1'(pq); v.scin = 1'(si);  v.cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        req = v.req;  stall = v.stall;  branch = v.branch;  lut_idx = v.idx;
        one_i = v.one; pari_i = v.pari; sc_o = v.sco; sc_clr = v.clr; sc_en = v.en;
        exp_q.push_back(v);
    endtask

    task automatic check_output(input int row);
        vec_t e;
        tick();
        if (exp_q.size() == 0) begin
            check($sformatf("row%0d_scoreboard_empty", row), 0, 1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("row%0d_pc", row),     32'(prog_ctr), e.pc);
            check($sformatf("row%0d_busy", row),   32'(busy),     32'(e.busy));
            check($sformatf("row%0d_done", row),   32'(done),     32'(e.done));
            check($sformatf("row%0d_one_q", row),  32'(one_q),    32'(e.oneq));
            check($sformatf("row%0d_pari_q", row), 32'(pari_q),   32'(e.pariq));
            check($sformatf("row%0d_sc_in", row),  32'(sc_in),    32'(e.scin));
            check($sformatf("row%0d_cycles", row), 32'(cycles),   e.cyc);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch = 0; lut_idx = 0; one_i = 0; pari_i = 0;
        sc_o = 0; sc_clr = 0; sc_en = 0; lut_we = 0;
    endtask

    initial begin
        //                req st br idx one par sco clr en |  pc bsy dn oq pq si cyc
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0,   1, 1, 0, 1, 1, 0, 1);
        vecs[2]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0,  40, 1, 0, 0, 0, 0, 2);
        vecs[3]  = mk(1, 0, 1, 3, 1, 0, 0, 0, 0,  41, 1, 0, 1, 0, 0, 3);
        vecs[4]  = mk(1, 1, 1, 3, 0, 1, 1, 0, 1,  41, 1, 0, 1, 0, 0, 3);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1,  42, 1, 0, 0, 0, 1, 4);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 1,  43, 1, 0, 0, 0, 0, 5);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1,  44, 1, 0, 0, 0, 1, 6);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  45, 1, 0, 0, 0, 1, 7);
        vecs[9]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 7);
        vecs[10] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 1, 7);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);

        #22;
        check("reset_pc", 32'(prog_ctr), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_cycles", 32'(cycles), 0);
        reset = 1'b1;

        // Load lut[3]=40 while idle.
        lut_we = 1; lut_waddr = 3; lut_wdata = 40;
        tick();
        lut_we = 0;
        check("idle_pc_after_lut_write", 32'(prog_ctr), 0);
        check("idle_busy_after_lut_write", 32'(busy), 0);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            check_output(i);
        end
        clear_inputs();

        // Write and branch-read the same entry on one edge: old value (0) wins.
        one_i = 1; tick();
        check("pre_same_edge_pc", 32'(prog_ctr), 1);
        branch = 1; lut_idx = 5; lut_we = 1; lut_waddr = 5; lut_wdata = 99;
        tick();
        check("same_edge_old_entry", 32'(prog_ctr), 0);
        lut_we = 0; one_i = 0;
        tick();
        check("branch_new_entry", 32'(prog_ctr), 99);
        clear_inputs();
        req = 0; tick();
        check("abort_to_idle_pc", 32'(prog_ctr), 0);

        // Full run to DONE_ADDR.
        req = 1; tick();
        check("run_start_busy", 32'(busy), 1);
        for (int i = 0; i < 165; i++) tick();
        check("run_pc_165", 32'(prog_ctr), 165);
        check("run_done_not_yet", 32'(done), 0);
        tick();
        check("done_asserted", 32'(done), 1);
        check("done_busy_low", 32'(busy), 0);
        check("done_cycles", 32'(cycles), 166);
        tick();
        check("done_pc_hold", 32'(prog_ctr), 165);
        check("done_cycles_hold", 32'(cycles), 166);
        req = 0; tick();
        check("done_exit_pc", 32'(prog_ctr), 0);
        check("done_exit_done", 32'(done), 0);
        check("idle_cycles_retained", 32'(cycles), 166);

        // Stall for five cycles at PC 10 with a would-be branch.
        req = 1; tick();
        for (int i = 0; i < 9; i++) tick();
        one_i = 1; tick();
        check("pre_stall_pc", 32'(prog_ctr), 10);
        stall = 1; branch = 1; lut_idx = 3; one_i = 0; pari_i = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d_pc", i), 32'(prog_ctr), 10);
            check($sformatf("stall%0d_cycles", i), 32'(cycles), 10);
            check($sformatf("stall%0d_one_q", i), 32'(one_q), 1);
            check($sformatf("stall%0d_pari_q", i), 32'(pari_q), 0);
        end
        stall = 0; branch = 0; pari_i = 0;
        tick();
        check("post_stall_pc", 32'(prog_ctr), 11);
        check("post_stall_cycles", 32'(cycles), 11);

        // Abort at PC 50.
        for (int i = 0; i < 39; i++) tick();
        check("pre_abort_pc", 32'(prog_ctr), 50);
        req = 0; tick();
        check("abort_pc", 32'(prog_ctr), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        tick();
        check("abort_done_stays_low", 32'(done), 0);

        // Asynchronous reset at PC 80, no clock edge needed.
        req = 1; one_i = 1; tick();
        for (int i = 0; i < 80; i++) tick();
        check("pre_reset_pc", 32'(prog_ctr), 80);
        #2 reset = 0;
        #1;
        check("async_reset_pc", 32'(prog_ctr), 0);
        check("async_reset_busy", 32'(busy), 0);
        check("async_reset_one_q", 32'(one_q), 0);
        check("async_reset_sc_in", 32'(sc_in), 0);
        check("async_reset_cycles", 32'(cycles), 0);
        req = 0; clear_inputs();
        #3 reset = 1;
        tick();
        check("post_reset_idle", 32'(busy), 0);
        req = 1; tick();
        one_i = 1; tick();
        branch = 1; lut_idx = 3; tick();
        check("lut_cleared_by_reset", 32'(prog_ctr), 0);
        clear_inputs(); req = 0; tick();

        // Small instance: run from 0 to DONE at PC 15.
        b_req = 1;
        begin
            int n = 0;
            while (!b_done && n < 40) begin
                tick();
                n++;
            end
            check("b_done_within_bound", 32'(b_done), 1);
            check("b_edges_to_done", n, 17);
        end
        check("b_pc_done", 32'(b_pc), 15);
        check("b_cycles", 32'(b_cycles), 16);
        check("b_flags", {29'd0, b_one, b_pari, b_sc}, 0);
        check("b_busy_low", 32'(b_busy), 0);
        b_req = 0; tick();
        check("b_idle_pc", 32'(b_pc), 0);

        // Unreachable DONE_ADDR: PC wraps and a 4-bit counter saturates.
        c_req = 1; tick();
        for (int i = 0; i < 15; i++) tick();
        check("c_pc_15", 32'(c_pc), 15);
        tick();
        check("c_pc_wrap", 32'(c_pc), 0);
        check("c_cycles_sat", 32'(c_cycles), 15);
        for (int i = 0; i < 4; i++) tick();
        check("c_pc_after_wrap", 32'(c_pc), 4);
        check("c_cycles_hold_sat", 32'(c_cycles), 15);
        check("c_busy", 32'(c_busy), 1);
        check("c_done", 32'(c_done), 0);
        check("c_flags", {29'd0, c_one, c_pari, c_sc}, 0);
        c_req = 0; tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/x9_sequencer.md
X9_SEQUENCER -- requirements
Module: x9_sequencer

Interface
REQ-001 Parameter D, default 12: program counter width.
REQ-002 Parameter LW, default 4: branch LUT index width; LUT holds 2**LW entries of D bits.
REQ-003 Parameter CW, default 16: cycle counter width.
REQ-004 Parameter DONE_ADDR, default 165: PC value that terminates a run.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 req  in  1  run request; level-sensitive, held high for the duration of a run.
REQ-008 stall  in  1  freeze PC, flags and cycle counter for this cycle.
REQ-009 branch  in  1  decoded branch instruction.
REQ-010 lut_idx  in  LW  branch LUT read index.
REQ-011 lut_we  in  1  LUT write enable.
REQ-012 lut_waddr  in  LW  LUT write index.
REQ-013 lut_wdata  in  D  LUT write data.
REQ-014 one_i / pari_i  in  1 each  current ALU one and parity flags.
REQ-015 sc_o  in  1  current ALU shift/carry out.
REQ-016 sc_clr / sc_en  in  1 each  shift/carry clear and load controls.
REQ-017 prog_ctr  out  D  current program counter.
REQ-018 one_q / pari_q / sc_in  out  1 each  lagging flag registers.
REQ-019 busy  out  1  high in RUN; done  out  1  high in DONE.
REQ-020 cycles  out  CW  executed-cycle count of the current or last run.

Function
REQ-021 FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both registered-state decodes.
REQ-022 IDLE: prog_ctr held at 0; req=1 -> RUN next edge, cycles cleared to 0 on that edge.
REQ-023 RUN, stall=0: if branch & one_q then prog_ctr <= lut[lut_idx], else prog_ctr <= prog_ctr+1 modulo 2**D (2**D-1 wraps to 0).
REQ-024 RUN, stall=1: prog_ctr, one_q, pari_q, sc_in, cycles all hold; stall has priority over branch.
REQ-025 RUN: cycles increments by 1 on every unstalled edge, saturating at 2**CW-1.
REQ-026 RUN with prog_ctr==DONE_ADDR (stalled or not) -> DONE next edge; prog_ctr and cycles hold thereafter.
REQ-027 RUN with req=0 -> IDLE next edge (abort), prog_ctr <= 0, done never asserted; abort has priority over REQ-026.
REQ-028 DONE: held while req=1; req=0 -> IDLE next edge, prog_ctr <= 0; cycles retains last value until next run starts.
REQ-029 Flags update only on unstalled RUN edges: one_q <= one_i, pari_q <= pari_i; sc_in <= 0 if sc_clr, else sc_o if sc_en, else hold (sc_clr dominates).
REQ-030 Flags hold in IDLE and DONE.
REQ-031 LUT read is combinational; write synchronous when lut_we=1, in any state; same-edge write and branch read to the same index uses the old entry.
REQ-032 Branch latency: target visible on prog_ctr one edge after the branch cycle; branch decision uses one_q (previous-cycle flag), never one_i.

Reset
REQ-033 reset=0 asynchronously forces state IDLE, prog_ctr=0, one_q=pari_q=sc_in=0, cycles=0, busy=0, done=0, all LUT entries 0.
REQ-034 Reset asserted mid-run discards the run; after release the block remains in IDLE until req is sampled high.

Verification
REQ-035 Reset release, req=1, no branches/stalls -> busy=1 from edge 1; prog_ctr=165 after 165 edges; done=1 next edge; cycles=166.
REQ-036 Write lut[3]=40; in RUN with one_q=1, branch=1, lut_idx=3 -> prog_ctr=40 next edge; same stimulus with one_q=0 -> prog_ctr+1.
REQ-037 stall=1 for 5 cycles at PC=10 -> prog_ctr, flags and cycles unchanged; branch ignored during stall; resumes at 11.
REQ-038 D=4, DONE_ADDR=15, branch to 14 from PC 15 never allowed: run from 0 -> DONE at PC 15; separate run with lut entry 0 and wrap check: PC 15+1 -> 0 when DONE_ADDR unreachable.
REQ-039 req dropped at PC=50 -> IDLE, prog_ctr=0, done stays 0; async reset at PC=80 -> all outputs 0 immediately, without a clock edge.
REQ-040 sc_clr=1 and sc_en=1 with sc_o=1 -> sc_in=0; CW=4 with a 20-cycle run -> cycles saturates at 15.
